// File: rtl/uart_rx_block_packer_if.sv
// Stream bundle between the UART receiver, the block packer and the AES core.
// The slave modport is the packer's view; master is the surrounding environment.
interface uart_rx_block_packer_if;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [127:0] m_blk_tdata;
  logic [15:0]  m_blk_tkeep;
  logic         m_blk_tvalid;
  logic         m_blk_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_blk_tready,
    output s_axis_tready, m_blk_tdata, m_blk_tkeep, m_blk_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_blk_tready,
    input  s_axis_tready, m_blk_tdata, m_blk_tkeep, m_blk_tvalid
  );
endinterface

// File: rtl/uart_rx_block_packer.sv
// Packs UART bytes into 128-bit AES blocks, padding and flushing a partial block on rx_idle.
// The output block sits in its own register so byte arrival is decoupled from the AES handshake.
module uart_rx_block_packer #(
  parameter int PAD_MODE = 0
) (
  input  logic Clk,
  input  logic Rst,
  input  logic En,
  input  logic rx_idle,
  output logic pad_flush,
  uart_rx_block_packer_if.slave bus
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_LOAD} state_t;

  state_t       state_q, state_d;
  logic [127:0] acc_q, acc_d, out_reg_q, out_reg_d;
  logic [15:0]  keep_acc_q, keep_acc_d, out_keep_q, out_keep_d;
  logic [4:0]   byte_cnt_q, byte_cnt_d;
  logic         out_valid_q, out_valid_d;
  logic         flush_q, flush_d;
  logic         pad_flush_q, pad_flush_d;

  logic         clr, accept, out_free, s_ready, do_pad, do_load;
  logic [4:0]   cnt_post;
  logic [3:0]   lane;
  logic [7:0]   pad_byte;

  assign clr      = Rst || !En;
  assign out_free = !out_valid_q || bus.m_blk_tready;
  assign accept   = bus.s_axis_tvalid && s_ready;
  assign cnt_post = byte_cnt_q + {4'd0, accept};
  assign lane     = 4'd15 - byte_cnt_q[3:0];
  assign pad_byte = (PAD_MODE == 1) ? {3'd0, 5'd16 - byte_cnt_q} : 8'h00;

  always_ff @(posedge Clk) begin
    if (clr) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // A byte accepted alongside rx_idle is counted before deciding between load and pad.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (cnt_post == 5'd16)                state_d = S_LOAD;
        else if (rx_idle && cnt_post != 5'd0) state_d = S_PAD;
      end
      S_PAD:  state_d = S_LOAD;
      S_LOAD: if (out_free) state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    do_pad  = 1'b0;
    do_load = 1'b0;
    unique case (state_q)
      S_FILL:  s_ready = (byte_cnt_q < 5'd16);
      S_PAD:   do_pad  = 1'b1;
      S_LOAD:  do_load = out_free;
      default: ;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    keep_acc_d  = keep_acc_q;
    byte_cnt_d  = byte_cnt_q;
    flush_d     = flush_q;
    out_reg_d   = out_reg_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q && !bus.m_blk_tready;
    pad_flush_d = 1'b0;
    if (accept) begin
      acc_d[{lane, 3'b000} +: 8] = bus.s_axis_tdata;
      keep_acc_d[lane]           = 1'b1;
      byte_cnt_d                 = cnt_post;
    end
    if (do_pad) begin
      for (int i = 0; i < 16; i++) begin
        if (!keep_acc_q[i]) acc_d[8*i +: 8] = pad_byte;
      end
      flush_d = 1'b1;
    end
    if (do_load) begin
      out_reg_d   = acc_q;
      out_keep_d  = keep_acc_q;
      out_valid_d = 1'b1;
      pad_flush_d = flush_q;
      acc_d       = '0;
      keep_acc_d  = '0;
      byte_cnt_d  = '0;
      flush_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (clr) begin
      acc_q       <= '0;
      keep_acc_q  <= '0;
      byte_cnt_q  <= '0;
      flush_q     <= 1'b0;
      out_reg_q   <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      pad_flush_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      keep_acc_q  <= keep_acc_d;
      byte_cnt_q  <= byte_cnt_d;
      flush_q     <= flush_d;
      out_reg_q   <= out_reg_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      pad_flush_q <= pad_flush_d;
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_blk_tdata   = out_reg_q;
  assign bus.m_blk_tkeep   = out_keep_q;
  assign bus.m_blk_tvalid  = out_valid_q;
  assign pad_flush         = pad_flush_q;

endmodule
